// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage_pkg
//  Purpose  : Shared opcode constants, instruction field positions and the
//             I-type classifier for the decode stage.
//  Revision : 1.0 - initial release
// ============================================================================
package id_stage_pkg;

    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_ANDI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;

    localparam int unsigned c_opc_lsb = 26;
    localparam int unsigned c_rs_lsb  = 21;
    localparam int unsigned c_rt_lsb  = 16;
    localparam int unsigned c_imm_lsb = 0;

    localparam int unsigned c_opc_w = 6;
    localparam int unsigned c_reg_w = 5;
    localparam int unsigned c_imm_w = 16;

    function automatic logic is_itype(input logic [5:0] opc);
        logic r;
        r = 1'b0;
        case (opc)
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage_if
//  Purpose  : Fetch handshake, write-back port and ALU-side output bundle of
//             the decode stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface id_stage_if;

    logic [31:0] inst_in;
    logic        inst_valid;
    logic        in_ready;

    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        ex_ready;
    logic        out_valid;
    logic [31:0] inst_reg;
    logic [31:0] ALU_I1;
    logic [15:0] ALU_I2;

    modport master (
        output inst_in, inst_valid, wb_en, wb_addr, wb_data, ex_ready,
        input  in_ready, out_valid, inst_reg, ALU_I1, ALU_I2
    );

    modport slave (
        input  inst_in, inst_valid, wb_en, wb_addr, wb_data, ex_ready,
        output in_ready, out_valid, inst_reg, ALU_I1, ALU_I2
    );

endinterface
`default_nettype wire

// File: rtl/id_stage_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : Architectural register file, one asynchronous read port, one
//             synchronous write port, register 0 reads as zero.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [4:0]        i_raddr,
    output logic      [DATA_W-1:0] o_rdata,
    input  wire logic              i_we,
    input  wire logic [4:0]        i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_regs [0:NREGS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Register 0 is forced to zero on the read side, so writes to it are moot.
    assign o_rdata = (i_raddr == 5'd0) ? '0 : r_regs[i_raddr];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : Decode stage for I-type ALU instructions: operand fetch with
//             write-back bypass, RAW scoreboard, output register handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    id_stage_if.slave             bus,
    output logic      [CNT_W-1:0] drop_cnt
);

    logic [5:0]       w_opc;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [15:0]      w_imm;
    logic             w_is_itype;
    logic             w_wb_hit_rs;
    logic             w_hazard;
    logic             w_in_ready;
    logic             w_accept;
    logic [31:0]      w_rf_rdata;
    logic [31:0]      w_rs_val;
    logic [NREGS-1:0] w_pending_nxt;

    logic [NREGS-1:0] r_pending;
    logic             r_out_valid;
    logic [31:0]      r_inst;
    logic [31:0]      r_alu_i1;
    logic [15:0]      r_alu_i2;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_opc = bus.inst_in[c_opc_lsb +: c_opc_w];
    assign w_rs  = bus.inst_in[c_rs_lsb  +: c_reg_w];
    assign w_rt  = bus.inst_in[c_rt_lsb  +: c_reg_w];
    assign w_imm = bus.inst_in[c_imm_lsb +: c_imm_w];

    assign w_is_itype  = is_itype(w_opc);
    assign w_wb_hit_rs = bus.wb_en && (bus.wb_addr == w_rs);

    // A pending source is not a hazard when its write-back lands this cycle.
    assign w_hazard   = w_is_itype && (w_rs != 5'd0) && r_pending[w_rs] && !w_wb_hit_rs;
    assign w_in_ready = (!r_out_valid || bus.ex_ready) && !w_hazard;
    assign w_accept   = bus.inst_valid && w_in_ready;

    reg_file #(
        .NREGS  (NREGS),
        .DATA_W (32)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .i_raddr (w_rs),
        .o_rdata (w_rf_rdata),
        .i_we    (bus.wb_en),
        .i_waddr (bus.wb_addr),
        .i_wdata (bus.wb_data)
    );

    always_comb begin
        w_rs_val = w_rf_rdata;
        if (w_rs == 5'd0) begin
            w_rs_val = '0;
        end else if (w_wb_hit_rs) begin
            w_rs_val = bus.wb_data;
        end
    end

    // Clear first, then set, so a same-cycle set of the same bit wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (bus.wb_en) begin
            w_pending_nxt[bus.wb_addr] = 1'b0;
        end
        if (w_accept && w_is_itype && (w_rt != 5'd0)) begin
            w_pending_nxt[w_rt] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_inst      <= '0;
            r_alu_i1    <= '0;
            r_alu_i2    <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_pending <= w_pending_nxt;

            if (w_accept && w_is_itype) begin
                r_out_valid <= 1'b1;
                r_inst      <= bus.inst_in;
                r_alu_i1    <= w_rs_val;
                r_alu_i2    <= w_imm;
            end else if (bus.ex_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept && !w_is_itype && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.inst_reg  = r_inst;
    assign bus.ALU_I1    = r_alu_i1;
    assign bus.ALU_I2    = r_alu_i2;
    assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Purpose  : Directed stimulus with a scoreboard queue for the decode stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] i1;
        logic [15:0] i2;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] drop_cnt;
    id_stage_if bus ();

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    id_stage #(
        .NREGS (32),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] i1, input logic [15:0] i2);
        exp_t e;
        e.inst = inst;
        e.i1   = i1;
        e.i2   = i2;
        exp_q.push_back(e);
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic issue(input logic [31:0] inst);
        bus.inst_in    = inst;
        bus.inst_valid = 1'b1;
    endtask

    // Monitor: every consumed output must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.ex_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got inst 0x%08h expected no output", bus.inst_reg);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_inst", bus.inst_reg, e.inst);
                chk("out_alu_i1", bus.ALU_I1, e.i1);
                chk("out_alu_i2", {16'h0, bus.ALU_I2}, {16'h0, e.i2});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ins;
        logic [31:0] ins2;
        logic        saw_ov;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.inst_in = '0;
        bus.inst_valid = 1'b0;
        bus.ex_ready = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_inst_reg", bus.inst_reg, 32'd0);
        chk("rst_alu_i1", bus.ALU_I1, 32'd0);
        chk("rst_alu_i2", 32'(bus.ALU_I2), 32'd0);

        // Basic operand read from the register file, one-cycle latency.
        wb(1'b1, 5'd5, 32'h0000_1234);
        step();
        wb(1'b0, 5'd0, 32'h0);
        ins = mk(6'd8, 5'd5, 5'd0, 16'h0010);
        issue(ins);
        push(ins, 32'h0000_1234, 16'h0010);
        step();
        bus.inst_valid = 1'b0;
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        chk("consumed_out_valid", 32'(bus.out_valid), 32'd0);

        // Same-cycle write-back bypass.
        wb(1'b1, 5'd5, 32'h0000_5555);
        ins = mk(6'd8, 5'd5, 5'd0, 16'h0020);
        issue(ins);
        push(ins, 32'h0000_5555, 16'h0020);
        step();
        bus.inst_valid = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        step();

        // RAW hazard on r7, released by its write-back.
        ins = mk(6'd11, 5'd0, 5'd7, 16'h00FF);
        issue(ins);
        push(ins, 32'h0, 16'h00FF);
        step();
        ins = mk(6'd8, 5'd7, 5'd0, 16'h0001);
        issue(ins);
        #1;
        chk("hazard_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("hazard_hold_in_ready", 32'(bus.in_ready), 32'd0);
        wb(1'b1, 5'd7, 32'h0000_00AA);
        #1;
        chk("wb_release_in_ready", 32'(bus.in_ready), 32'd1);
        push(ins, 32'h0000_00AA, 16'h0001);
        step();
        wb(1'b0, 5'd0, 32'h0);
        ins = mk(6'd9, 5'd7, 5'd0, 16'h0002);
        issue(ins);
        #1;
        chk("cleared_in_ready", 32'(bus.in_ready), 32'd1);
        push(ins, 32'h0000_00AA, 16'h0002);
        step();

        // Pending set and clear of r9 in the same cycle: set wins.
        ins = mk(6'd11, 5'd0, 5'd9, 16'h0003);
        issue(ins);
        wb(1'b1, 5'd9, 32'h0000_0077);
        push(ins, 32'h0, 16'h0003);
        step();
        wb(1'b0, 5'd0, 32'h0);
        ins = mk(6'd8, 5'd9, 5'd0, 16'h0004);
        issue(ins);
        #1;
        chk("set_wins_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        wb(1'b1, 5'd9, 32'h0000_0099);
        push(ins, 32'h0000_0099, 16'h0004);
        step();
        bus.inst_valid = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        step();

        // Downstream stall for three cycles.
        bus.ex_ready = 1'b0;
        ins = mk(6'd10, 5'd5, 5'd0, 16'h0ABC);
        issue(ins);
        push(ins, 32'h0000_5555, 16'h0ABC);
        step();
        ins2 = mk(6'd8, 5'd0, 5'd0, 16'h2222);
        issue(ins2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_inst_reg", bus.inst_reg, ins);
            chk("stall_alu_i1", bus.ALU_I1, 32'h0000_5555);
            chk("stall_alu_i2", 32'(bus.ALU_I2), 32'h0000_0ABC);
            step();
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
        push(ins2, 32'h0, 16'h2222);
        step();
        bus.inst_valid = 1'b0;
        step();

        // Opcode boundaries around the I-type range.
        issue(mk(6'd7, 5'd5, 5'd0, 16'h0000));
        step();
        issue(mk(6'd13, 5'd5, 5'd0, 16'h0000));
        step();
        ins = mk(6'd12, 5'd5, 5'd0, 16'h0007);
        issue(ins);
        push(ins, 32'h0000_5555, 16'h0007);
        step();
        bus.inst_valid = 1'b0;
        #1;
        chk("boundary_drop_cnt", 32'(drop_cnt), 32'd2);
        step();

        // Flood of R-type instructions saturates the drop counter.
        saw_ov = 1'b0;
        issue(mk(6'd0, 5'd1, 5'd2, 16'h0020));
        for (int i = 0; i < 300; i++) begin
            step();
            if (bus.out_valid) saw_ov = 1'b1;
            if (i == 251) chk("drop_cnt_254", 32'(drop_cnt), 32'd254);
        end
        bus.inst_valid = 1'b0;
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        chk("rtype_no_out", 32'(saw_ov), 32'd0);

        // r0 stays zero; reset mid-operation discards the held instruction.
        bus.ex_ready = 1'b0;
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        ins = mk(6'd12, 5'd0, 5'd3, 16'h8000);
        issue(ins);
        step();
        bus.inst_valid = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("r0_out_valid", 32'(bus.out_valid), 32'd1);
        chk("r0_alu_i1", bus.ALU_I1, 32'h0);
        chk("r0_alu_i2", 32'(bus.ALU_I2), 32'h0000_8000);
        exp_q.delete();
        rst = 1'b1;
        wb(1'b1, 5'd5, 32'h0000_DEAD);
        issue(mk(6'd8, 5'd0, 5'd4, 16'h0001));
        step();
        rst = 1'b0;
        bus.inst_valid = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        bus.ex_ready = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        ins = mk(6'd8, 5'd3, 5'd0, 16'h0005);
        issue(ins);
        #1;
        chk("midrst_pending_clear", 32'(bus.in_ready), 32'd1);
        push(ins, 32'h0, 16'h0005);
        step();
        ins = mk(6'd8, 5'd5, 5'd0, 16'h0006);
        issue(ins);
        push(ins, 32'h0, 16'h0006);
        step();
        bus.inst_valid = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            step();
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter NREGS, default 32, number of architectural registers (5-bit specifiers).
REQ-002 Parameter CNT_W, default 8, width of the dropped-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inst_in  input  32  fetched instruction: opcode [31:26], rs [25:21], rt [20:16], imm [15:0].
REQ-006 inst_valid  input  1  inst_in is valid this cycle.
REQ-007 in_ready  output  1  stage accepts inst_in this cycle.
REQ-008 wb_en  input  1  register write-back strobe.
REQ-009 wb_addr  input  5  write-back destination register.
REQ-010 wb_data  input  32  write-back value.
REQ-011 ex_ready  input  1  downstream I-type ALU stage consumes the output register this cycle.
REQ-012 out_valid  output  1  output register holds a valid instruction.
REQ-013 inst_reg  output  32  registered instruction to the ALU stage.
REQ-014 ALU_I1  output  32  registered rs operand.
REQ-015 ALU_I2  output  16  registered immediate, zero-extended by the consumer.
REQ-016 drop_cnt  output  CNT_W  count of non-I-type instructions discarded.

Function
REQ-017 I-type = opcode 8..12 inclusive (addi, addiu, andi, ori, slti); all other opcodes are non-I-type.
REQ-018 hazard = inst_in is I-type, rs != 0, pending[rs] = 1, and NOT (wb_en and wb_addr == rs).
REQ-019 in_ready = (!out_valid or ex_ready) and !hazard; combinational, never depends on inst_valid.
REQ-020 Accept = inst_valid and in_ready; latency accept-to-out_valid is exactly 1 cycle.
REQ-021 On accept of I-type: inst_reg <= inst_in, ALU_I2 <= imm, out_valid <= 1.
REQ-022 ALU_I1 on accept: 0 if rs == 0; else wb_data if wb_en and wb_addr == rs (same-cycle bypass); else regfile[rs].
REQ-023 On accept of non-I-type: instruction discarded, out_valid <= 0 if ex_ready else held, drop_cnt increments, saturating at all-ones.
REQ-024 out_valid and !ex_ready and no accept: inst_reg, ALU_I1, ALU_I2, out_valid held bit-stable.
REQ-025 out_valid and ex_ready and no accept: out_valid <= 0; data outputs may hold stale values.
REQ-026 Write-back: wb_en with wb_addr != 0 writes regfile[wb_addr]; wb_addr == 0 ignored, register 0 reads 0.
REQ-027 Scoreboard: accepting I-type with rt != 0 sets pending[rt]; wb_en clears pending[wb_addr].
REQ-028 Set and clear of the same pending bit in one cycle: set wins.
REQ-029 Write-back is independent of in_ready/ex_ready and is never stalled.

Reset
REQ-030 While rst is high at a clk edge: out_valid, inst_reg, ALU_I1, ALU_I2, drop_cnt, all pending bits and all registers <= 0.
REQ-031 Reset mid-operation discards the held output instruction; inst_in and write-back that cycle are ignored.
REQ-032 in_ready SHALL evaluate per REQ-019 from reset state (1 in the first cycle after reset).

Structure
REQ-033 Shared package holds opcode constants OP_ADDI=8, OP_ADDIU=9, OP_ANDI=10, OP_ORI=11, OP_SLTI=12, and field bit positions.
REQ-034 Register file is sub-module reg_file: one async read port, one sync write port, register 0 hardwired zero, reset-clearable.
REQ-035 Scoreboard, handshake and output register live in id_stage itself.

Verification
REQ-036 Reset, write r5=0x0000_1234, issue addi rs=5 imm=0x0010, ex_ready=1 -> next cycle out_valid=1, ALU_I1=0x1234, ALU_I2=0x0010.
REQ-037 Issue ori rt=7, then addi rs=7 with no write-back -> in_ready=0; wb r7=0xAA same cycle -> accepted, ALU_I1=0xAA.
REQ-038 ex_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; ex_ready=1 -> next instruction accepted.
REQ-039 Issue opcode 0 (R-type) 300 times -> drop_cnt=255, out_valid never asserted.
REQ-040 wb r0=0xFFFF_FFFF, issue slti rs=0 -> ALU_I1=0; assert rst with out_valid=1 -> next cycle out_valid=0, all pending clear.
